// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and shared constants for the I2C write responder.
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP} state_t;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;
    localparam int CNT_W = 4;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with rise/fall detection on the synced level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    always_comb begin
        sync_d = STAGES'({sync_q, d});
        prev_d = sync_q[STAGES-1];
        q      = sync_q[STAGES-1];
        rise   = q & ~prev_q;
        fall   = ~q & prev_q;
    end
    // Reset to 1 so an idle bus produces no spurious edges on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end
endmodule

// File: rtl/i2c_responder.sv
// i2c_responder: I2C target accepting 3-byte writes (device address, 7-bit register
// address plus data MSB, data low byte) and emitting a one-cycle write strobe.
module i2c_responder import i2c_pkg::*; #(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_busy,
    output logic [7:0] o_nack_count
);
    logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, byte1_q, byte1_d, nack_q, nack_d, rx;
    logic oe_q, oe_d, valid_q, valid_d, busy_q, busy_d, byte_done;
    logic [6:0] addr_q, addr_d;
    logic [8:0] data_q, data_d;

    sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .clk(i_clk), .rst(i_rst), .d(i_scl), .q(scl), .rise(scl_rise), .fall(scl_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .clk(i_clk), .rst(i_rst), .d(i_sda), .q(sda), .rise(sda_rise), .fall(sda_fall)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        byte1_d   = byte1_q;
        nack_d    = nack_q;
        oe_d      = oe_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rx        = {shift_q[6:0], sda};
        byte_done = scl_rise && cnt_q == CNT_W'(7);
        case (state_q)
            ADDR, BYTE1, BYTE2: if (scl_rise) begin
                shift_d = rx;
                cnt_d   = cnt_q + 1'b1;
                if (byte_done && state_q == ADDR) begin
                    state_d = rx == {DEV_ADDR, 1'b0} ? ACK_A : WAIT_STOP;
                    nack_d  = rx == {DEV_ADDR, 1'b0} || nack_q == 8'hFF ? nack_q : nack_q + 8'd1;
                end else if (byte_done) begin
                    state_d = state_q == BYTE1 ? ACK_1 : ACK_2;
                    byte1_d = state_q == BYTE1 ? rx : byte1_q;
                end
            end
            // First SCL fall in an ACK state drives SDA low, the second releases it and moves on.
            ACK_A, ACK_1, ACK_2: if (scl_fall) begin
                oe_d = ~oe_q;
                if (oe_q) begin
                    cnt_d   = '0;
                    state_d = state_q == ACK_A ? BYTE1 : state_q == ACK_1 ? BYTE2 : WAIT_STOP;
                    valid_d = state_q == ACK_2;
                    addr_d  = state_q == ACK_2 ? byte1_q[7:1] : addr_q;
                    data_d  = state_q == ACK_2 ? {byte1_q[0], shift_q} : data_q;
                end
            end
            default: ;
        endcase
        // START/STOP override whatever the byte engine decided this cycle.
        if ((sda_fall || sda_rise) && scl) begin
            state_d = sda_fall ? ADDR : IDLE;
            busy_d  = sda_fall;
            cnt_d   = '0;
            oe_d    = 1'b0;
            valid_d = 1'b0;
            addr_d  = addr_q;
            data_d  = data_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            byte1_q <= '0;
            nack_q  <= '0;
            oe_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            byte1_q <= byte1_d;
            nack_q  <= nack_d;
            oe_q    <= oe_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign o_sda_oe     = oe_q;
    assign o_wr_valid   = valid_q;
    assign o_wr_addr    = addr_q;
    assign o_wr_data    = data_q;
    assign o_busy       = busy_q;
    assign o_nack_count = nack_q;
endmodule
